prince_sbox_cms_compress: RTL and testbench



---
 rtl/prince_cms_pkg.sv | 27 ++
 rtl/prince_cms_compress_xor.sv | 14 +
 rtl/prince_sbox_cms_compress.sv | 88 ++++++++
 tb/tb_prince_sbox_cms_compress.sv | 378 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prince_cms_pkg.sv
// Shared sizing for the PRINCE CMS S-box datapath and the term-to-share
// grouping used when compressing CMS output terms.
package prince_cms_pkg;

    localparam int NBITS   = 4;
    localparam int NTERMS  = 8;
    localparam int NSHARES = 3;
    localparam int NNIB    = 16;
    localparam int IDXW    = $clog2(NNIB);

    // Term t of a bit folds into output share share_of(t).
    function automatic int share_of(input int t);
        return (t * NSHARES) / NTERMS;
    endfunction

    function automatic logic [NTERMS-1:0] share_mask(input int s);
        logic [NTERMS-1:0] m;
        m = '0;
        for (int t = 0; t < NTERMS; t++) begin
            if (share_of(t) == s) begin
                m = m | (NTERMS'(1) << t);
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/prince_cms_compress_xor.sv
// Combinational XOR tree folding the CMS terms of one S-box output bit
// into NSHARES shares.
module prince_cms_compress_xor
    import prince_cms_pkg::*;
(
    input  logic [NTERMS-1:0]  terms,
    output logic [NSHARES-1:0] shares
);

    for (genvar s = 0; s < NSHARES; s++) begin : g_share
        assign shares[s] = ^(terms & share_mask(s));
    end

endmodule

// File: rtl/prince_sbox_cms_compress.sv
// Glitch-barrier register for the CMS S-box terms, followed by XOR
// compression to three shares per bit and a registered nibble output.
module prince_sbox_cms_compress
    import prince_cms_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NBITS*NTERMS-1:0]   in_terms,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [NBITS*NSHARES-1:0]  out_shares,
    output logic                      out_last,
    output logic [IDXW-1:0]           out_idx
);

    logic                     valid_a;
    logic                     valid_b;
    logic [NBITS*NTERMS-1:0]  term_q;
    logic [NBITS*NSHARES-1:0] shares_q;
    logic [NBITS*NSHARES-1:0] shares_d;
    logic [IDXW-1:0]          idx;
    logic                     advance_a;
    logic                     advance_b;
    logic                     accept;
    logic                     out_fire;

    // A transfer happens on a rising edge where valid and ready are both high;
    // a producer holds valid and data stable until then, and ready never
    // depends on valid of the same interface.
    assign advance_b = !valid_b || out_ready;
    assign advance_a = valid_a && advance_b;
    assign in_ready  = !valid_a || advance_b;
    assign accept    = in_valid && in_ready;
    assign out_fire  = valid_b && out_ready;

    // Compression reads only the registered terms, never in_terms.
    for (genvar b = 0; b < NBITS; b++) begin : g_bit
        logic [NSHARES-1:0] bit_shares;

        prince_cms_compress_xor u_xor (
            .terms  (term_q[b*NTERMS +: NTERMS]),
            .shares (bit_shares)
        );

        for (genvar s = 0; s < NSHARES; s++) begin : g_map
            assign shares_d[s*NBITS+b] = bit_shares[s];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_a  <= 1'b0;
            valid_b  <= 1'b0;
            idx      <= '0;
            term_q   <= '0;
            shares_q <= '0;
        end else if (flush) begin
            valid_a <= 1'b0;
            valid_b <= 1'b0;
            idx     <= '0;
        end else begin
            if (in_ready) begin
                valid_a <= in_valid;
            end
            if (advance_b) begin
                valid_b <= valid_a;
            end
            if (accept) begin
                term_q <= in_terms;
            end
            if (advance_a) begin
                shares_q <= shares_d;
            end
            if (out_fire) begin
                idx <= (idx == IDXW'(NNIB-1)) ? '0 : idx + 1'b1;
            end
        end
    end

    assign out_valid  = valid_b;
    assign out_shares = shares_q;
    assign out_idx    = idx;
    assign out_last   = valid_b && (idx == IDXW'(NNIB-1));

endmodule

// File: tb/tb_prince_sbox_cms_compress.sv
// Self-checking bench: directed scenarios plus a randomized stream checked
// against a term-level model of the masked nibble compression.
module tb_prince_sbox_cms_compress;
    import prince_cms_pkg::*;

    localparam int TW = NBITS*NTERMS;
    localparam int SW = NBITS*NSHARES;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [TW-1:0]   in_terms = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SW-1:0]   out_shares;
    logic            out_last;
    logic [IDXW-1:0] out_idx;

    int checks = 0;
    int errors = 0;
    logic [SW-1:0]    exp_q[$];
    logic [NBITS-1:0] par_q[$];
    int exp_idx = 0;
    int out_cnt = 0;

    prince_sbox_cms_compress dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_terms   (in_terms),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_shares (out_shares),
        .out_last   (out_last),
        .out_idx    (out_idx)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Reference model
    function automatic logic [SW-1:0] compress(input logic [TW-1:0] terms);
        logic [SW-1:0] r;
        logic [TW-1:0] tmp;
        logic x;
        r = '0;
        for (int b = 0; b < NBITS; b++) begin
            for (int s = 0; s < NSHARES; s++) begin
                x = 1'b0;
                for (int t = 0; t < NTERMS; t++) begin
                    if (share_of(t) == s) begin
                        tmp = terms >> (b*NTERMS + t);
                        x = x ^ tmp[0];
                    end
                end
                r = r | (SW'(x) << (s*NBITS + b));
            end
        end
        return r;
    endfunction

    function automatic logic [NBITS-1:0] term_parity(input logic [TW-1:0] terms);
        logic [NBITS-1:0] p;
        logic [TW-1:0] tmp;
        p = '0;
        for (int b = 0; b < NBITS; b++) begin
            tmp = terms >> (b*NTERMS);
            p = p | (NBITS'(^tmp[NTERMS-1:0]) << b);
        end
        return p;
    endfunction

    function automatic logic [NBITS-1:0] unshare(input logic [SW-1:0] sh);
        logic [NBITS-1:0] p;
        logic [SW-1:0] tmp;
        p = '0;
        for (int s = 0; s < NSHARES; s++) begin
            tmp = sh >> (s*NBITS);
            p = p ^ tmp[NBITS-1:0];
        end
        return p;
    endfunction

    // Scoreboard
    task automatic monitor();
        logic [SW-1:0]    exp_s;
        logic [NBITS-1:0] exp_p;
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n || flush) begin
                exp_q.delete();
                par_q.delete();
                exp_idx = 0;
            end else begin
                if (out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL sb_extra: unexpected beat shares=%h", out_shares);
                    end else begin
                        exp_s = exp_q.pop_front();
                        exp_p = par_q.pop_front();
                        if (out_shares !== exp_s) begin
                            errors++;
                            $display("FAIL sb_shares: got %h exp %h", out_shares, exp_s);
                        end
                        checks++;
                        if (unshare(out_shares) !== exp_p) begin
                            errors++;
                            $display("FAIL sb_unshared: got %h exp %h", unshare(out_shares), exp_p);
                        end
                    end
                    checks++;
                    if (out_idx !== IDXW'(exp_idx)) begin
                        errors++;
                        $display("FAIL sb_idx: got %0d exp %0d", out_idx, exp_idx);
                    end
                    checks++;
                    if (out_last !== (exp_idx == NNIB-1)) begin
                        errors++;
                        $display("FAIL sb_last: got %b exp %b at idx %0d", out_last, (exp_idx == NNIB-1), exp_idx);
                    end
                    exp_idx = (exp_idx + 1) % NNIB;
                    out_cnt++;
                end
                if (in_valid && in_ready) begin
                    exp_q.push_back(compress(in_terms));
                    par_q.push_back(term_parity(in_terms));
                end
            end
        end
    endtask

    // Driver tasks
    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b exp 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b exp 1", in_ready); end
        checks++;
        if (out_shares !== '0) begin errors++; $display("FAIL rst_shares: got %h exp 0", out_shares); end
        checks++;
        if (out_idx !== '0) begin errors++; $display("FAIL rst_idx: got %0d exp 0", out_idx); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL rst_last: got %b exp 0", out_last); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        in_terms  = TW'(32'h80808080);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b exp 0", out_valid); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b exp 1", out_valid); end
        checks++;
        if (out_shares !== SW'(12'hF00)) begin errors++; $display("FAIL single_shares: got %h exp f00", out_shares); end
        checks++;
        if (out_idx !== '0) begin errors++; $display("FAIL single_idx: got %0d exp 0", out_idx); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL single_last: got %b exp 0", out_last); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL single_after: got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        int k;
        drain();
        do_flush();
        out_ready = 1'b1;
        for (int c = 0; c < 19; c++) begin
            in_valid = (c < 17);
            in_terms = TW'($urandom());
            @(posedge clk); #1;
            if (c >= 1 && c <= 17) begin
                k = c - 1;
                checks++;
                if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: beat %0d got %b exp 1", k, out_valid); end
                checks++;
                if (out_idx !== IDXW'(k % NNIB)) begin errors++; $display("FAIL b2b_idx: beat %0d got %0d exp %0d", k, out_idx, k % NNIB); end
                checks++;
                if (out_last !== (k == NNIB-1)) begin errors++; $display("FAIL b2b_last: beat %0d got %b exp %b", k, out_last, (k == NNIB-1)); end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc;
        logic fire;
        logic have;
        logic [SW-1:0] held;
        drain();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_terms  = TW'($urandom());
        acc  = 0;
        have = 1'b0;
        held = '0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            fire = in_ready;
            if (fire) acc++;
            if (out_valid) begin
                if (!have) begin
                    held = out_shares;
                    have = 1'b1;
                end else begin
                    checks++;
                    if (out_shares !== held) begin errors++; $display("FAIL bp_stable: cycle %0d got %h exp %h", c, out_shares, held); end
                end
            end
            @(posedge clk); #1;
            if (fire) in_terms = TW'($urandom());
        end
        checks++;
        if (acc != 2) begin errors++; $display("FAIL bp_accepts: got %0d exp 2", acc); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b exp 0", in_ready); end
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid: got %b exp 1", out_valid); end
        drain();
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL bp_lost: got %0d pending exp 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        int cyc;
        int found;
        drain();
        do_flush();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        found = 0;
        cyc = 0;
        while (!found && cyc < 40) begin
            in_terms = TW'($urandom());
            @(posedge clk); #1;
            cyc++;
            if (out_valid && out_idx == IDXW'(7)) found = 1;
        end
        checks++;
        if (!found) begin errors++; $display("FAIL flush_reach7: got timeout exp idx 7"); end
        flush    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b exp 0", out_valid); end
        checks++;
        if (out_idx !== '0) begin errors++; $display("FAIL flush_idx: got %0d exp 0", out_idx); end
        in_terms = TW'($urandom());
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 10) begin
            @(posedge clk); #1;
            cyc++;
        end
        checks++;
        if (!out_valid) begin errors++; $display("FAIL flush_next: got timeout exp beat"); end
        checks++;
        if (out_idx !== '0) begin errors++; $display("FAIL flush_next_idx: got %0d exp 0", out_idx); end
        drain();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        repeat (4) begin
            in_terms = TW'($urandom());
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        repeat (3) begin
            in_terms = TW'($urandom());
            @(posedge clk); #1;
        end
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ar_full: got valid=%b ready=%b exp valid=1 ready=0", out_valid, in_ready);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b exp 0", out_valid); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_in_ready: got %b exp 1", in_ready); end
        checks++;
        if (out_shares !== '0) begin errors++; $display("FAIL ar_shares: got %h exp 0", out_shares); end
        checks++;
        if (out_idx !== '0) begin errors++; $display("FAIL ar_idx: got %0d exp 0", out_idx); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL ar_last: got %b exp 0", out_last); end
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int sent;
        int start;
        int cyc;
        logic acc;
        sent  = 0;
        start = out_cnt;
        cyc   = 0;
        acc   = 1'b0;
        in_valid = 1'b0;
        while ((sent < 1000 || out_cnt - start < 1000) && cyc < 20000) begin
            if (!in_valid || acc) begin
                if (sent < 1000 && $urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_terms = TW'($urandom());
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            if (acc) sent++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checks++;
        if (out_cnt - start != 1000) begin errors++; $display("FAIL rand_count: got %0d beats exp 1000", out_cnt - start); end
        checks++;
        if (exp_q.size() != 0) begin errors++; $display("FAIL rand_pending: got %0d exp 0", exp_q.size()); end
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
